// File: rtl/signal_sequencer.sv
// signal_sequencer: four-way intersection phase controller.
// Latches pedestrian and turn requests and sequences MAIN, TURN and PED phases through
// timed all-red CLEAR intervals. Lamp outputs are registered decodes of the state register.
// Optional feature: define SIGNAL_AMBER_EN to insert an AMBER interval before every CLEAR
// that follows a green phase (adds the amber port and the AMBER_TIME parameter).
module signal_sequencer #(
  parameter int unsigned TIMER_W    = 8,
  parameter int unsigned MIN_GREEN  = 8,
  parameter int unsigned TURN_TIME  = 6,
  parameter int unsigned PED_TIME   = 10,
  parameter int unsigned CLEAR_TIME = 2
`ifdef SIGNAL_AMBER_EN
  ,
  parameter int unsigned AMBER_TIME = 3
`endif
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       pedestrian_button,
  input  logic       turn_sensor,
  output logic       pedestrian_green,
  output logic       up_green,
  output logic       down_green,
  output logic       turn_green,
`ifdef SIGNAL_AMBER_EN
  output logic       amber,
`endif
  output logic [1:0] phase
);

  // Encodings of MAIN/TURN/PED equal their phase codes; AMBER reports phase 0.
  typedef enum logic [2:0] {
    StClear = 3'd0,
    StMain  = 3'd1,
    StTurn  = 3'd2,
    StPed   = 3'd3,
    StAmber = 3'd4
  } state_e;

  // A timed state of length N exits on the edge where the timer reads N-1.
  localparam logic [TIMER_W-1:0] TimerMax     = '1;
  localparam logic [TIMER_W-1:0] MinGreenLast = TIMER_W'(MIN_GREEN - 1);
  localparam logic [TIMER_W-1:0] TurnLast     = TIMER_W'(TURN_TIME - 1);
  localparam logic [TIMER_W-1:0] PedLast      = TIMER_W'(PED_TIME - 1);
  localparam logic [TIMER_W-1:0] ClearLast    = TIMER_W'(CLEAR_TIME - 1);
`ifdef SIGNAL_AMBER_EN
  localparam logic [TIMER_W-1:0] AmberLast    = TIMER_W'(AMBER_TIME - 1);
`endif

  state_e             state_q, state_d;
  state_e             nxt_q, nxt_d;
  state_e             green_exit;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               ped_req_q, ped_req_d;
  logic               turn_req_q, turn_req_d;
  logic               last_ped_q, last_ped_d;

  // Where a green phase goes when it ends.
`ifdef SIGNAL_AMBER_EN
  assign green_exit = StAmber;
`else
  assign green_exit = StClear;
`endif

  // Next-state, phase timer and request latch logic.
  always_comb begin
    state_d    = state_q;
    nxt_d      = nxt_q;
    last_ped_d = last_ped_q;
    case (state_q)
      StClear: begin
        if (timer_q == ClearLast) state_d = nxt_q;
      end
      StMain: begin
        if ((timer_q >= MinGreenLast) && (ped_req_q || turn_req_q)) begin
          // With both pending, alternate on last_ped so neither request starves.
          if (ped_req_q && (!turn_req_q || !last_ped_q)) begin
            nxt_d      = StPed;
            last_ped_d = 1'b1;
          end else begin
            nxt_d      = StTurn;
            last_ped_d = 1'b0;
          end
          state_d = green_exit;
        end
      end
      StTurn: begin
        if (timer_q == TurnLast) begin
          state_d = green_exit;
          nxt_d   = StMain;
        end
      end
      StPed: begin
        if (timer_q == PedLast) begin
          state_d = green_exit;
          nxt_d   = StMain;
        end
      end
`ifdef SIGNAL_AMBER_EN
      StAmber: begin
        if (timer_q == AmberLast) state_d = StClear;
      end
`endif
      default: state_d = StClear;
    endcase

    if (state_d != state_q) begin
      timer_d = '0;
    end else if (timer_q == TimerMax) begin
      timer_d = timer_q;
    end else begin
      timer_d = timer_q + 1'b1;
    end

    // Entering a phase serves its request, overriding a same-cycle set.
    ped_req_d  = (ped_req_q || (pedestrian_button && (state_q != StPed))) &&
                 !((state_d == StPed) && (state_q != StPed));
    turn_req_d = (turn_req_q || (turn_sensor && (state_q != StTurn))) &&
                 !((state_d == StTurn) && (state_q != StTurn));
  end

  // State registers plus registered Moore decode of the current state onto the lamps.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q          <= StClear;
      nxt_q            <= StMain;
      timer_q          <= '0;
      ped_req_q        <= 1'b0;
      turn_req_q       <= 1'b0;
      last_ped_q       <= 1'b0;
      pedestrian_green <= 1'b0;
      up_green         <= 1'b0;
      down_green       <= 1'b0;
      turn_green       <= 1'b0;
      phase            <= 2'd0;
`ifdef SIGNAL_AMBER_EN
      amber            <= 1'b0;
`endif
    end else begin
      state_q          <= state_d;
      nxt_q            <= nxt_d;
      timer_q          <= timer_d;
      ped_req_q        <= ped_req_d;
      turn_req_q       <= turn_req_d;
      last_ped_q       <= last_ped_d;
      pedestrian_green <= (state_q == StPed);
      up_green         <= (state_q == StMain) || (state_q == StTurn);
      down_green       <= (state_q == StMain);
      turn_green       <= (state_q == StTurn);
      if ((state_q == StMain) || (state_q == StTurn) || (state_q == StPed)) begin
        phase <= state_q[1:0];
      end else begin
        phase <= 2'd0;
      end
`ifdef SIGNAL_AMBER_EN
      amber            <= (state_q == StAmber);
`endif
    end
  end

endmodule

// File: tb/tb_signal_sequencer.sv
// Self-checking bench for signal_sequencer: phase-level reference model checked every
// cycle, plus directed scenarios with literal expected lamp vectors.
module tb_signal_sequencer;

  localparam int MIN_GREEN  = 8;
  localparam int TURN_TIME  = 6;
  localparam int PED_TIME   = 10;
  localparam int CLEAR_TIME = 2;
  localparam int AMBER_TIME = 3;

  // Lamp vector layout: [6]=amber [5]=ped [4]=up [3]=down [2]=turn [1:0]=phase
  localparam logic [7:0] V_RED   = 8'h00;
  localparam logic [7:0] V_MAIN  = 8'h19;
  localparam logic [7:0] V_TURN  = 8'h16;
  localparam logic [7:0] V_PED   = 8'h23;
  localparam logic [7:0] V_AMBER = 8'h40;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       pedestrian_button;
  logic       turn_sensor;
  logic       pedestrian_green;
  logic       up_green;
  logic       down_green;
  logic       turn_green;
  logic [1:0] phase;
  logic       amber_bit;
`ifdef SIGNAL_AMBER_EN
  logic       amber;
  assign amber_bit = amber;
`else
  assign amber_bit = 1'b0;
`endif

  int tests = 0;
  int failures = 0;

  signal_sequencer dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .pedestrian_button (pedestrian_button),
    .turn_sensor       (turn_sensor),
    .pedestrian_green  (pedestrian_green),
    .up_green          (up_green),
    .down_green        (down_green),
    .turn_green        (turn_green),
`ifdef SIGNAL_AMBER_EN
    .amber             (amber),
`endif
    .phase             (phase)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] obs();
    return {1'b0, amber_bit, pedestrian_green, up_green, down_green, turn_green, phase};
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] expv);
    tests++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %02h, expected %02h", name, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic restart();
    reset_n = 1'b0;
    pedestrian_button = 1'b0;
    turn_sensor = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  // ---------------- Reference model ----------------
  // Phase codes: 0 clear, 1 main, 2 turn, 3 ped, 4 amber. Timed phases count down the
  // cycles they have left; MAIN counts its age. Lamps show the phase held before the edge.
  int  m_st, m_left, m_age, m_next, exp_st;
  bit  m_ped, m_turn, m_last_ped;
  bit  m_live = 1'b0;

  function automatic int after_green();
`ifdef SIGNAL_AMBER_EN
    return 4;
`else
    return 0;
`endif
  endfunction

  function automatic int len_of(input int s);
    case (s)
      0:       return CLEAR_TIME;
      2:       return TURN_TIME;
      3:       return PED_TIME;
      4:       return AMBER_TIME;
      default: return 0;
    endcase
  endfunction

  function automatic logic [7:0] exp_vec(input int s);
    case (s)
      1:       return V_MAIN;
      2:       return V_TURN;
      3:       return V_PED;
      4:       return V_AMBER;
      default: return V_RED;
    endcase
  endfunction

  always @(posedge clock) begin
    int nst;
    bit ped_n, turn_n;
    if (!reset_n) begin
      m_st = 0; m_left = CLEAR_TIME; m_age = 0; m_next = 1;
      m_ped = 0; m_turn = 0; m_last_ped = 0; exp_st = 0; m_live = 1'b1;
    end else if (m_live) begin
      exp_st = m_st;
      ped_n  = m_ped  | (pedestrian_button && m_st != 3);
      turn_n = m_turn | (turn_sensor && m_st != 2);
      nst = m_st;
      if (m_st == 1) begin
        if (m_age >= MIN_GREEN && (m_ped || m_turn)) begin
          m_next = (m_ped && (!m_turn || !m_last_ped)) ? 3 : 2;
          m_last_ped = (m_next == 3);
          nst = after_green();
        end else begin
          m_age++;
        end
      end else if (m_left == 1) begin
        if (m_st == 0) nst = m_next;
        else if (m_st == 4) nst = 0;
        else begin
          nst = after_green();
          m_next = 1;
        end
      end else begin
        m_left--;
      end
      if (nst != m_st) begin
        m_left = len_of(nst);
        m_age = 1;
        if (nst == 3) ped_n = 0;
        if (nst == 2) turn_n = 0;
      end
      m_st = nst; m_ped = ped_n; m_turn = turn_n;
    end
  end

  // ---------------- Per-cycle compare and safety properties ----------------
  logic [7:0] prev_obs = 8'h00;

  always @(negedge clock) begin
    logic [7:0] o;
    o = obs();
    if (m_live) begin
      check("model", o, exp_vec(exp_st));
      if (o[5]) check("ped_vs_through", 8'({o[4], o[3]}), 8'h00);
      if (o[2]) check("turn_vs_down", 8'(o[3]), 8'h00);
      if ((o[5:2] & ~prev_obs[5:2]) != 4'b0) check("green_after_green", 8'(prev_obs[5:2]), 8'h00);
    end
    prev_obs = o;
  end

  // ---------------- Directed scenarios ----------------
  function automatic logic [7:0] ped_pulse_exp(input int e);
    if ((e >= 3 && e <= 10) || e >= 25) return V_MAIN;
    if (e >= 13 && e <= 22) return V_PED;
    return V_RED;
  endfunction

  initial begin
    int seq[$];
    int lens[$];
    int prev;
    reset_n = 1'b0;
    pedestrian_button = 1'b0;
    turn_sensor = 1'b0;
    tick();
    check("reset_state", obs(), V_RED);

    // Reset release with no requests: red for two edges, then MAIN held.
    reset_n = 1'b1;
    for (int e = 1; e <= 210; e++) begin
      tick();
      check($sformatf("idle e=%0d", e), obs(), (e <= 2) ? V_RED : V_MAIN);
    end

`ifndef SIGNAL_AMBER_EN
    // One-cycle pedestrian pulse sampled while the MAIN timer reads 2.
    restart();
    for (int e = 1; e <= 30; e++) begin
      pedestrian_button = (e == 5);
      tick();
      check($sformatf("ped_pulse e=%0d", e), obs(), ped_pulse_exp(e));
    end
    pedestrian_button = 1'b0;

    // Both requests held: service alternates PED and TURN between MAIN phases.
    restart();
    pedestrian_button = 1'b1;
    turn_sensor = 1'b1;
    prev = 0;
    for (int e = 1; e <= 80; e++) begin
      tick();
      if (phase != 2'd0) begin
        if (int'(phase) == prev) lens[$] = lens[$] + 1;
        else begin
          seq.push_back(int'(phase));
          lens.push_back(1);
        end
      end
      prev = int'(phase);
    end
    pedestrian_button = 1'b0;
    turn_sensor = 1'b0;
    check("order_count", 8'(seq.size() >= 6), 8'h01);
    if (seq.size() >= 6) begin
      check("order0", 8'(seq[0]), 8'd1);
      check("order1", 8'(seq[1]), 8'd3);
      check("order2", 8'(seq[2]), 8'd1);
      check("order3", 8'(seq[3]), 8'd2);
      check("order4", 8'(seq[4]), 8'd1);
      check("order5", 8'(seq[5]), 8'd3);
      check("main_len", 8'(lens[0]), 8'd8);
      check("ped_len", 8'(lens[1]), 8'd10);
      check("turn_len", 8'(lens[3]), 8'd6);
    end

    // Reset in the middle of PED, with a turn request latched during PED.
    restart();
    for (int e = 1; e <= 17; e++) begin
      pedestrian_button = (e == 5);
      turn_sensor = (e == 15);
      tick();
    end
    check("in_ped", obs(), V_PED);
    reset_n = 1'b0;
    pedestrian_button = 1'b0;
    turn_sensor = 1'b0;
    tick();
    check("midped_reset", obs(), V_RED);
    reset_n = 1'b1;
    for (int e = 1; e <= 30; e++) begin
      tick();
      check($sformatf("after_reset e=%0d", e), obs(), (e <= 2) ? V_RED : V_MAIN);
    end
`else
    // Turn request: MAIN, three amber cycles, two all-red cycles, then the turn arrow.
    restart();
    for (int e = 1; e <= 16; e++) begin
      turn_sensor = (e == 1);
      tick();
      if (e <= 2) check($sformatf("amber e=%0d", e), obs(), V_RED);
      else if (e <= 10) check($sformatf("amber e=%0d", e), obs(), V_MAIN);
      else if (e <= 13) check($sformatf("amber e=%0d", e), obs(), V_AMBER);
      else if (e <= 15) check($sformatf("amber e=%0d", e), obs(), V_RED);
      else check($sformatf("amber e=%0d", e), obs(), V_TURN);
    end
    turn_sensor = 1'b0;
`endif

    // Random stimulus, checked each cycle by the model and the safety properties.
    restart();
    for (int i = 0; i < 10000; i++) begin
      pedestrian_button = ($urandom_range(0, 15) == 0);
      turn_sensor = ($urandom_range(0, 11) == 0);
      reset_n = ($urandom_range(0, 1999) != 0);
      tick();
    end
    reset_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
